// File: rtl/regfile_scoreboard_if.sv
// Operand-read, issue, write-back and flush signals between the pipeline and the register file.
// The pipeline drives through the master modport; the register file takes the slave modport.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_busy1;
  logic              rd_busy2;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_dst;
  logic              issue_ready;
  logic              wb0_en;
  logic [ADDR_W-1:0] wb0_addr;
  logic [DATA_W-1:0] wb0_data;
  logic              wb1_en;
  logic [ADDR_W-1:0] wb1_addr;
  logic [DATA_W-1:0] wb1_data;
  logic              flush;
  logic              err_underflow;

  modport master (
    output rd_addr1, rd_addr2, issue_valid, issue_dst,
           wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data, flush,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2, issue_ready, err_underflow
  );

  modport slave (
    input  rd_addr1, rd_addr2, issue_valid, issue_dst,
           wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data, flush,
    output rd_data1, rd_data2, rd_busy1, rd_busy2, issue_ready, err_underflow
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with two write-back ports, two bypassed read ports and a per-register
// pending-write counter used by ID to detect RAW hazards.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PEND_W = 2
) (
  input logic                  CLK,
  input logic                  RST,
  regfile_scoreboard_if.slave  bus
);
  localparam int NREG = 2 ** ADDR_W;
  localparam int CW   = PEND_W + 2;
  typedef logic signed [CW-1:0] scnt_t;
  localparam scnt_t CNT_MAX_S = scnt_t'((1 << PEND_W) - 1);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [PEND_W-1:0] cnt_q  [NREG];
  logic [PEND_W-1:0] cnt_d  [NREG];
  logic              err_q;
  logic              err_d;

  function automatic logic [1:0] retire_cnt(
    input logic [ADDR_W-1:0] a,
    input logic e0, input logic [ADDR_W-1:0] a0,
    input logic e1, input logic [ADDR_W-1:0] a1
  );
    retire_cnt = {1'b0, (e0 && (a0 == a))} + {1'b0, (e1 && (a1 == a))};
  endfunction

  // Pending count after this cycle's retirements, ignoring this cycle's issue.
  function automatic scnt_t eff_cnt(input logic [PEND_W-1:0] c, input logic [1:0] ret);
    eff_cnt = $signed({2'b00, c}) - $signed({{PEND_W{1'b0}}, ret});
  endfunction

  function automatic logic [DATA_W-1:0] read_mux(
    input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] stored,
    input logic e0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
    input logic e1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1
  );
    if (a == {ADDR_W{1'b0}}) begin
      read_mux = {DATA_W{1'b0}};
    end else if (e0 && (a0 == a)) begin
      read_mux = d0;
    end else if (e1 && (a1 == a)) begin
      read_mux = d1;
    end else begin
      read_mux = stored;
    end
  endfunction

  logic [1:0] ret1_s, ret2_s, ret_iss_s;

  // Read ports, busy flags and issue acceptance.
  always_comb begin
    ret1_s    = retire_cnt(bus.rd_addr1, bus.wb0_en, bus.wb0_addr, bus.wb1_en, bus.wb1_addr);
    ret2_s    = retire_cnt(bus.rd_addr2, bus.wb0_en, bus.wb0_addr, bus.wb1_en, bus.wb1_addr);
    ret_iss_s = retire_cnt(bus.issue_dst, bus.wb0_en, bus.wb0_addr, bus.wb1_en, bus.wb1_addr);
    bus.rd_data1 = read_mux(bus.rd_addr1, regs_q[bus.rd_addr1], bus.wb0_en, bus.wb0_addr,
                            bus.wb0_data, bus.wb1_en, bus.wb1_addr, bus.wb1_data);
    bus.rd_data2 = read_mux(bus.rd_addr2, regs_q[bus.rd_addr2], bus.wb0_en, bus.wb0_addr,
                            bus.wb0_data, bus.wb1_en, bus.wb1_addr, bus.wb1_data);
    bus.rd_busy1 = (bus.rd_addr1 != {ADDR_W{1'b0}}) &&
                   (eff_cnt(cnt_q[bus.rd_addr1], ret1_s) > scnt_t'(0));
    bus.rd_busy2 = (bus.rd_addr2 != {ADDR_W{1'b0}}) &&
                   (eff_cnt(cnt_q[bus.rd_addr2], ret2_s) > scnt_t'(0));
    bus.issue_ready = (bus.issue_dst == {ADDR_W{1'b0}}) ||
                      (eff_cnt(cnt_q[bus.issue_dst], ret_iss_s) < CNT_MAX_S);
    bus.err_underflow = err_q;
  end

  logic  uf_s;
  scnt_t nxt_s;
  logic  inc_s, dec0_s, dec1_s;

  // Next-state for data, pending counters and the underflow flag.
  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    uf_s   = 1'b0;
    nxt_s  = scnt_t'(0);
    inc_s  = 1'b0;
    dec0_s = 1'b0;
    dec1_s = 1'b0;
    // wb0 is written last so it wins a same-address collision with wb1.
    if (bus.wb1_en && (bus.wb1_addr != {ADDR_W{1'b0}})) begin
      regs_d[bus.wb1_addr] = bus.wb1_data;
    end else begin
      regs_d[0] = {DATA_W{1'b0}};
    end
    if (bus.wb0_en && (bus.wb0_addr != {ADDR_W{1'b0}})) begin
      regs_d[bus.wb0_addr] = bus.wb0_data;
    end else begin
      regs_d[0] = {DATA_W{1'b0}};
    end
    cnt_d[0] = {PEND_W{1'b0}};
    for (int r = 1; r < NREG; r++) begin
      inc_s  = bus.issue_valid && bus.issue_ready && (bus.issue_dst == ADDR_W'(r));
      dec0_s = bus.wb0_en && (bus.wb0_addr == ADDR_W'(r));
      dec1_s = bus.wb1_en && (bus.wb1_addr == ADDR_W'(r));
      nxt_s  = $signed({2'b00, cnt_q[r]}) + $signed({{(CW-1){1'b0}}, inc_s})
             - $signed({{(CW-1){1'b0}}, dec0_s}) - $signed({{(CW-1){1'b0}}, dec1_s});
      if (nxt_s < scnt_t'(0)) begin
        cnt_d[r] = {PEND_W{1'b0}};
        uf_s     = 1'b1;
      end else if (nxt_s > CNT_MAX_S) begin
        cnt_d[r] = CNT_MAX_S[PEND_W-1:0];
      end else begin
        cnt_d[r] = nxt_s[PEND_W-1:0];
      end
    end
    if (bus.flush) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_d[r] = {PEND_W{1'b0}};
      end
      err_d = 1'b0;
    end else begin
      err_d = uf_s;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= {DATA_W{1'b0}};
        cnt_q[r]  <= {PEND_W{1'b0}};
      end
      err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed checks of the register file scoreboard: bypass, busy tracking, issue
// back-pressure, write collisions, underflow, flush and asynchronous reset.
module tb_regfile_scoreboard;
  logic CLK;
  logic RST;
  int   n_cmp;
  int   n_bad;

  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .PEND_W(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.wb0_en      = 1'b0;
    bus.wb1_en      = 1'b0;
    bus.flush       = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    RST = 1'b0;
    bus.rd_addr1 = 5'd0;  bus.rd_addr2 = 5'd0;
    bus.issue_dst = 5'd0; bus.wb0_addr = 5'd0; bus.wb1_addr = 5'd0;
    bus.wb0_data = 32'h0; bus.wb1_data = 32'h0;
    idle();
    #12;
    RST = 1'b1;
    #1;

    // 1: reset state, write and bypass
    bus.rd_addr1 = 5'd5;
    bus.issue_dst = 5'd3;
    #1;
    chk("rst_data", bus.rd_data1, 32'h0);
    chk("rst_busy", {31'b0, bus.rd_busy1}, 32'h0);
    chk("rst_err", {31'b0, bus.err_underflow}, 32'h0);
    chk("rst_ready", {31'b0, bus.issue_ready}, 32'h1);
    bus.wb0_en = 1'b1; bus.wb0_addr = 5'd5; bus.wb0_data = 32'h1234_5678;
    #1;
    chk("t1_bypass", bus.rd_data1, 32'h1234_5678);
    tick();
    idle();
    #1;
    chk("t1_stored", bus.rd_data1, 32'h1234_5678);
    chk("t1_busy", {31'b0, bus.rd_busy1}, 32'h0);
    chk("t1_r0", bus.rd_data2, 32'h0);

    // 2: issue r7, busy, then same-cycle final retirement via wb1
    bus.issue_valid = 1'b1; bus.issue_dst = 5'd7;
    #1;
    chk("t2_ready", {31'b0, bus.issue_ready}, 32'h1);
    tick();
    idle();
    bus.rd_addr2 = 5'd7;
    #1;
    chk("t2_busy", {31'b0, bus.rd_busy2}, 32'h1);
    bus.wb1_en = 1'b1; bus.wb1_addr = 5'd7; bus.wb1_data = 32'hA5A5_A5A5;
    #1;
    chk("t2_busy_clr", {31'b0, bus.rd_busy2}, 32'h0);
    chk("t2_bypass", bus.rd_data2, 32'hA5A5_A5A5);
    tick();
    idle();
    #1;
    chk("t2_stored", bus.rd_data2, 32'hA5A5_A5A5);
    chk("t2_err", {31'b0, bus.err_underflow}, 32'h0);

    // 3: saturate r3, held issue, retire frees a slot the same cycle
    bus.rd_addr1 = 5'd3;
    bus.issue_valid = 1'b1; bus.issue_dst = 5'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_ready_fill", {31'b0, bus.issue_ready}, 32'h1);
      tick();
    end
    #1;
    chk("t3_full", {31'b0, bus.issue_ready}, 32'h0);
    tick();
    chk("t3_held", {31'b0, bus.issue_ready}, 32'h0);
    bus.wb0_en = 1'b1; bus.wb0_addr = 5'd3; bus.wb0_data = 32'h0000_0033;
    #1;
    chk("t3_ready_wb", {31'b0, bus.issue_ready}, 32'h1);
    tick();
    bus.issue_valid = 1'b0; bus.wb0_en = 1'b0;
    #1;
    chk("t3_full_again", {31'b0, bus.issue_ready}, 32'h0);
    bus.wb0_en = 1'b1;
    #1;
    chk("t3_drain3", {31'b0, bus.rd_busy1}, 32'h1);
    tick();
    chk("t3_drain2", {31'b0, bus.rd_busy1}, 32'h1);
    tick();
    chk("t3_drain1", {31'b0, bus.rd_busy1}, 32'h0);
    tick();
    idle();
    #1;
    chk("t3_err", {31'b0, bus.err_underflow}, 32'h0);

    // 4: both ports to r9, wb0 data wins, two retirements
    bus.issue_valid = 1'b1; bus.issue_dst = 5'd9;
    tick();
    tick();
    idle();
    bus.rd_addr1 = 5'd9;
    #1;
    chk("t4_busy", {31'b0, bus.rd_busy1}, 32'h1);
    bus.wb0_en = 1'b1; bus.wb0_addr = 5'd9; bus.wb0_data = 32'h0000_1111;
    bus.wb1_en = 1'b1; bus.wb1_addr = 5'd9; bus.wb1_data = 32'h0000_2222;
    #1;
    chk("t4_bypass", bus.rd_data1, 32'h0000_1111);
    chk("t4_busy_clr", {31'b0, bus.rd_busy1}, 32'h0);
    tick();
    idle();
    #1;
    chk("t4_stored", bus.rd_data1, 32'h0000_1111);
    chk("t4_busy_after", {31'b0, bus.rd_busy1}, 32'h0);
    chk("t4_err", {31'b0, bus.err_underflow}, 32'h0);

    // 5: retire to an idle register raises a one-cycle underflow pulse
    bus.rd_addr1 = 5'd4;
    bus.wb0_en = 1'b1; bus.wb0_addr = 5'd4; bus.wb0_data = 32'h0000_0044;
    #1;
    chk("t5_err_pre", {31'b0, bus.err_underflow}, 32'h0);
    tick();
    idle();
    chk("t5_err_pulse", {31'b0, bus.err_underflow}, 32'h1);
    chk("t5_busy", {31'b0, bus.rd_busy1}, 32'h0);
    tick();
    chk("t5_err_clr", {31'b0, bus.err_underflow}, 32'h0);

    // 6: flush clears reservations, overrides issue, suppresses underflow
    bus.issue_valid = 1'b1; bus.issue_dst = 5'd2;
    tick();
    bus.issue_dst = 5'd6;
    tick();
    idle();
    bus.rd_addr1 = 5'd2; bus.rd_addr2 = 5'd6;
    #1;
    chk("t6_busy2", {31'b0, bus.rd_busy1}, 32'h1);
    chk("t6_busy6", {31'b0, bus.rd_busy2}, 32'h1);
    bus.flush = 1'b1;
    bus.issue_valid = 1'b1; bus.issue_dst = 5'd2;
    bus.wb0_en = 1'b1; bus.wb0_addr = 5'd4; bus.wb0_data = 32'h0000_0055;
    tick();
    idle();
    chk("t6_flush2", {31'b0, bus.rd_busy1}, 32'h0);
    chk("t6_flush6", {31'b0, bus.rd_busy2}, 32'h0);
    chk("t6_flush_err", {31'b0, bus.err_underflow}, 32'h0);
    bus.rd_addr2 = 5'd4;
    #1;
    chk("t6_flush_write", bus.rd_data2, 32'h0000_0055);

    // 6b: asynchronous reset in the middle of an issue
    bus.issue_valid = 1'b1; bus.issue_dst = 5'd2;
    tick();
    bus.issue_dst = 5'd6;
    bus.rd_addr2 = 5'd9;
    #1;
    chk("t6_pre_rst_busy", {31'b0, bus.rd_busy1}, 32'h1);
    #1;
    RST = 1'b0;
    #1;
    chk("t6_rst_busy", {31'b0, bus.rd_busy1}, 32'h0);
    chk("t6_rst_data", bus.rd_data2, 32'h0);
    bus.rd_addr1 = 5'd5;
    #1;
    chk("t6_rst_r5", bus.rd_data1, 32'h0);
    idle();
    tick();
    RST = 1'b1;
    bus.rd_addr2 = 5'd6;
    tick();
    chk("t6_rst_busy6", {31'b0, bus.rd_busy2}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
